motoro3_pwm_ramp_ctrl: RTL
==========================

# motoro3_pwm_ramp_ctrl

Step-synchronous duty scheduler for the motoro3 PWM generator: it owns the generator's `plLen` (pulse length per commutation step) input and moves it toward a software target in bounded increments. Changes happen only at commutation boundaries. The block handles soft-start, controlled stop and fault shutdown. It sits between the register block and the PWM generator, and consumes the step counter's `m3cntLast1` boundary strobe.

## Interface
Parameters:
- `PL_MAX`, 16'hFFF0: upper clamp applied to any accepted target.
- `PL_MIN_RUN`, 16'd32: smallest non-zero `plLen` ever driven (MOS driver minimum on-time).
- `WDOG_CYC`, 24'd2_000_000: boundary-watchdog timeout in clocks (only with `M3_RAMP_WATCHDOG_EN`).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: 10 MHz system clock; all logic is on the rising edge.
- `rst` in 1: synchronous active-high reset.
- `en` in 1: run request, level.
- `fault` in 1: external fault, level (overcurrent etc.).
- `m3cntLast1` in 1: one-cycle strobe on the last clock of each commutation step.
- `cfgValid` in 1: new target/step offered.
- `cfgTarget` in 16: requested `plLen`.
- `cfgStep` in 16: maximum `plLen` change per boundary.
- `cfgReady` out 1: the controller accepts a config this cycle.
- `plLen` out 16: pulse length driven to the PWM generator.
- `rampBusy` out 1: high in RAMP and STOP.
- `faultLatched` out 1: high in FAULT.
- `state` out 3: current state encoding.

## Operation
- State encodings: IDLE=0, RAMP=1, HOLD=2, STOP=3, FAULT=4.
- Reset values: `plLen`=0, `state`=IDLE, `tgt`=0, `stp`=1, `cfgReady`=1, `rampBusy`=0, `faultLatched`=0.
- Config accept:
  - A config is accepted on a cycle with `cfgValid & cfgReady`.
  - `cfgReady` = state is IDLE, RAMP or HOLD.
  - On accept: `tgt` = min(`cfgTarget`, `PL_MAX`); `stp` = (`cfgStep`==0) ? 1 : `cfgStep`.
  - A non-zero `tgt` below `PL_MIN_RUN` is raised to `PL_MIN_RUN`.
- IDLE: `plLen`=0. The controller enters RAMP when `en` & `tgt`≠0.
- RAMP, on each `m3cntLast1`:
  - If `plLen`<`tgt`: `plLen` = min(max(`plLen`+`stp`, `PL_MIN_RUN`), `tgt`).
  - If `plLen`>`tgt`: `plLen` = max(`plLen`−`stp`, `tgt`).
  - Sums use 17-bit arithmetic; results saturate and never wrap.
  - When `plLen`==`tgt` after the update, the next state is HOLD.
- HOLD: `plLen` is unchanged. An accepted config with a new `tgt`≠`plLen` moves the controller to RAMP.
- STOP:
  - Entered from RAMP or HOLD when `en` falls, or when `tgt` becomes 0.
  - On each boundary, `plLen` = `plLen`−`stp`. If the result is below `PL_MIN_RUN` or underflows, `plLen`=0.
  - At `plLen`==0 the controller goes to IDLE.
  - If `en` rises again during STOP, it is ignored until IDLE is reached.
- FAULT:
  - Entered from any state when `fault`=1.
  - This has priority over every other transition and does not wait for a boundary.
  - `plLen`=0 from the next cycle.
  - The controller leaves to IDLE only when `fault`=0 and `en`=0 together. `tgt` is cleared on entry.

## Timing
- `plLen` updates one clock after the `m3cntLast1` cycle. Between boundaries it is stable, except for a FAULT entry.
- Config accepted in the same cycle as `m3cntLast1`: that boundary's update uses the old `tgt`/`stp`. The new values apply from the next boundary.
- `fault` and `m3cntLast1` in the same cycle: FAULT wins, and `plLen`=0 next cycle.
- `en` falls in the same cycle as a boundary in RAMP: the state becomes STOP, and no ramp-up increment is applied.
- `rst` asserted mid-ramp: all outputs take their reset values on the next edge.
- `cfgReady` is combinational from `state`. It deasserts in the cycle after entering STOP or FAULT.

## Configuration
- `M3_RAMP_WATCHDOG_EN` defined:
  - A 24-bit counter clears on each `m3cntLast1` and counts while the state is RAMP, HOLD or STOP.
  - When it reaches `WDOG_CYC`, the controller enters FAULT as if `fault`=1 (stalled rotor or lost step counter).
  - The counter is held at 0 in IDLE and FAULT.
- Not defined: no counter is built, and FAULT is entered only via `fault`.

## Test plan
- Soft-start: reset, then config target=1000, step=300, then `en`=1 with boundaries every 50 clocks. Required: `plLen` goes 300, 600, 900, 1000; then HOLD with `rampBusy`=0.
- Minimum clamp: target=500, step=10. Required: first boundary gives `plLen`=32, then 42, 52, …; a target of 5 is held as 32.
- Stop: in HOLD at 1000 with step=300, drop `en`. Required: `plLen` goes 700, 400, 100, 0; then IDLE. Raising `en` during STOP has no effect before IDLE.
- Same-cycle config and boundary: in HOLD at 1000, pulse cfg target=400 step=600 together with `m3cntLast1`. Required: `plLen` stays 1000 that boundary, then becomes 400 at the next.
- Fault: assert `fault` mid-ramp. Required: `plLen`=0 next clock, `faultLatched`=1, `cfgReady`=0. Releasing `fault` with `en`=1 keeps FAULT; dropping `en` returns to IDLE.
- Watchdog (macro on, `WDOG_CYC`=100): in HOLD, withhold boundaries for 100 clocks. Required: FAULT and `plLen`=0. With the macro off, the controller stays in HOLD.

Source files
------------

// File: rtl/motoro3_pwm_ramp_ctrl_if.sv
// ---------------------------------------------------------------------------
// motoro3_pwm_ramp_ctrl_if
//
// Configuration handshake between the register block (master) and the
// motoro3 PWM ramp controller (slave). A config is taken on any cycle where
// cfgValid and cfgReady are both high.
//
// Signals:
//   cfgValid  master->slave  new target/step offered
//   cfgTarget master->slave  requested pulse length (plLen units)
//   cfgStep   master->slave  largest plLen change allowed per boundary
//   cfgReady  slave->master  controller can take a config this cycle
// ---------------------------------------------------------------------------
interface motoro3_pwm_ramp_ctrl_if;

    logic        cfgValid;
    logic [15:0] cfgTarget;
    logic [15:0] cfgStep;
    logic        cfgReady;

    // Register block side: offers configs and watches for acceptance
    modport master (
        output cfgValid,
        output cfgTarget,
        output cfgStep,
        input  cfgReady
    );

    // Ramp controller side: consumes configs and reports readiness
    modport slave (
        input  cfgValid,
        input  cfgTarget,
        input  cfgStep,
        output cfgReady
    );

endinterface

// File: rtl/motoro3_pwm_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// motoro3_pwm_ramp_ctrl
//
// Step-synchronous duty scheduler for the motoro3 PWM generator. It owns the
// generator's plLen input and walks it toward a software target by at most
// one step per commutation boundary (m3cntLast1), giving soft-start,
// controlled stop and immediate fault shutdown.
//
// Ports:
//   clk          10 MHz system clock, rising edge
//   rst          synchronous active-high reset
//   en           run request (level)
//   fault        external fault (level), forces FAULT immediately
//   m3cntLast1   one-cycle strobe on the last clock of a commutation step
//   cfg          config handshake (slave modport): cfgValid/cfgTarget/
//                cfgStep in, cfgReady out
//   plLen        pulse length driven to the PWM generator
//   rampBusy     high while ramping or stopping
//   faultLatched high while in FAULT
//   state        current state (IDLE=0 RAMP=1 HOLD=2 STOP=3 FAULT=4)
//
// Build option:
//   M3_RAMP_WATCHDOG_EN  when defined, a boundary watchdog forces FAULT if
//                        no m3cntLast1 arrives within WDOG_CYC clocks while
//                        the motor is meant to be turning.
// ---------------------------------------------------------------------------
module motoro3_pwm_ramp_ctrl #(
    parameter logic [15:0] PL_MAX     = 16'hFFF0,
    parameter logic [15:0] PL_MIN_RUN = 16'd32,
    parameter logic [23:0] WDOG_CYC   = 24'd2_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          fault,
    input  logic                          m3cntLast1,
    motoro3_pwm_ramp_ctrl_if.slave        cfg,
    output logic [15:0]                   plLen,
    output logic                          rampBusy,
    output logic                          faultLatched,
    output logic [2:0]                    state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        HOLD  = 3'd2,
        STOP  = 3'd3,
        FAULT = 3'd4
    } stateT;

    stateT       stateQ;
    stateT       stateD;

    logic [15:0] tgt;
    logic [15:0] stp;

    logic        accept;
    logic [15:0] clampTgt;
    logic [15:0] newTgt;
    logic [15:0] newStp;
    logic [15:0] tgtNext;

    logic [16:0] sumUp;
    logic [16:0] upFloor;
    logic [16:0] diffDn;
    logic [15:0] upVal;
    logic [15:0] dnVal;
    logic [15:0] rampVal;
    logic [15:0] stopVal;

    logic        wdogTrip;

    // Config decode. The target is clamped to PL_MAX and any non-zero target
    // below the driver's minimum on-time is lifted to PL_MIN_RUN, so every
    // plLen we ever settle on is either 0 or drivable. A zero step would
    // stall the ramp forever, so it is treated as 1. tgtNext is the target
    // as it will be after this edge, used to decide stop/hold transitions.
    always_comb begin
        accept   = cfg.cfgValid & cfg.cfgReady;
        clampTgt = (cfg.cfgTarget > PL_MAX) ? PL_MAX : cfg.cfgTarget;
        newTgt   = ((clampTgt != 16'd0) && (clampTgt < PL_MIN_RUN)) ? PL_MIN_RUN : clampTgt;
        newStp   = (cfg.cfgStep == 16'd0) ? 16'd1 : cfg.cfgStep;
        tgtNext  = accept ? newTgt : tgt;
    end

    // Candidate plLen values for the next boundary, computed with the
    // registered tgt/stp so a config arriving on a boundary only takes
    // effect from the following one. All sums carry a 17th bit: bit 16 of
    // the difference flags underflow, and the sum is compared against tgt
    // before truncation so neither direction can wrap.
    always_comb begin
        sumUp   = {1'b0, plLen} + {1'b0, stp};
        upFloor = (sumUp < {1'b0, PL_MIN_RUN}) ? {1'b0, PL_MIN_RUN} : sumUp;
        upVal   = (upFloor > {1'b0, tgt}) ? tgt : upFloor[15:0];
        diffDn  = {1'b0, plLen} - {1'b0, stp};
        dnVal   = (diffDn[16] || (diffDn[15:0] < tgt)) ? tgt : diffDn[15:0];

        if (plLen < tgt) begin
            rampVal = upVal;
        end else if (plLen > tgt) begin
            rampVal = dnVal;
        end else begin
            rampVal = plLen;
        end

        // While stopping, anything below the minimum on-time is cut to zero
        // rather than driving a pulse the MOS driver cannot honour.
        stopVal = (diffDn[16] || (diffDn[15:0] < PL_MIN_RUN)) ? 16'd0 : diffDn[15:0];
    end

`ifdef M3_RAMP_WATCHDOG_EN
    logic [23:0] wdogCnt;

    // Boundary watchdog: measures clocks since the last m3cntLast1 while the
    // motor should be turning. A stalled rotor or a dead step counter stops
    // the strobes, and we must not keep driving a fixed duty into it. The
    // count saturates at the limit and is parked at zero in IDLE/FAULT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdogCnt <= 24'd0;
        end else if ((stateQ == IDLE) || (stateQ == FAULT) || m3cntLast1) begin
            wdogCnt <= 24'd0;
        end else if (wdogCnt < WDOG_CYC) begin
            wdogCnt <= wdogCnt + 24'd1;
        end
    end

    assign wdogTrip = ((stateQ == RAMP) || (stateQ == HOLD) || (stateQ == STOP)) &&
                      (wdogCnt >= WDOG_CYC);
`else
    // Without the watchdog FAULT is reached only through the fault input.
    // WDOG_CYC is folded into a constant-false term so the parameter list is
    // the same in both builds.
    assign wdogTrip = 1'b0 & (WDOG_CYC == 24'd0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic. Fault (or a watchdog trip) overrides everything and
    // does not wait for a boundary. Losing the run request or a zero target
    // sends RAMP/HOLD into STOP immediately; once in STOP we only leave when
    // plLen has reached zero, so a re-raised en is ignored until IDLE. In
    // RAMP the hold decision compares against tgtNext so a config landing on
    // the same boundary that hits the old target keeps us ramping.
    always_comb begin
        stateD = stateQ;
        if (fault || wdogTrip) begin
            stateD = FAULT;
        end else begin
            unique case (stateQ)
                IDLE: begin
                    if (en && (tgt != 16'd0)) begin
                        stateD = RAMP;
                    end
                end
                RAMP: begin
                    if (!en || (tgtNext == 16'd0)) begin
                        stateD = STOP;
                    end else if (m3cntLast1 && (rampVal == tgtNext)) begin
                        stateD = HOLD;
                    end
                end
                HOLD: begin
                    if (!en || (tgtNext == 16'd0)) begin
                        stateD = STOP;
                    end else if (accept && (newTgt != plLen)) begin
                        stateD = RAMP;
                    end
                end
                STOP: begin
                    if ((plLen == 16'd0) || (m3cntLast1 && (stopVal == 16'd0))) begin
                        stateD = IDLE;
                    end
                end
                FAULT: begin
                    if (!en) begin
                        stateD = IDLE;
                    end
                end
                default: begin
                    stateD = FAULT;
                end
            endcase
        end
    end

    // Outputs decoded purely from the registered state, so cfgReady drops
    // in the first cycle spent in STOP or FAULT.
    always_comb begin
        cfg.cfgReady = (stateQ == IDLE) || (stateQ == RAMP) || (stateQ == HOLD);
        rampBusy     = (stateQ == RAMP) || (stateQ == STOP);
        faultLatched = (stateQ == FAULT);
        state        = stateQ;
    end

    // Datapath registers. A FAULT entry zeroes plLen and forgets the target
    // so recovery needs a fresh config. Otherwise plLen only moves on a
    // boundary: ramp updates are skipped when the same edge leaves for STOP
    // (en fell or target went to zero), and STOP decrements toward zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            plLen <= 16'd0;
            tgt   <= 16'd0;
            stp   <= 16'd1;
        end else if (stateD == FAULT) begin
            plLen <= 16'd0;
            tgt   <= 16'd0;
        end else begin
            if (accept) begin
                tgt <= newTgt;
                stp <= newStp;
            end
            unique case (stateQ)
                IDLE, FAULT: begin
                    plLen <= 16'd0;
                end
                RAMP: begin
                    if (m3cntLast1 && (stateD != STOP)) begin
                        plLen <= rampVal;
                    end
                end
                STOP: begin
                    if (m3cntLast1) begin
                        plLen <= stopVal;
                    end
                end
                default: begin
                    plLen <= plLen;
                end
            endcase
        end
    end

endmodule
